// File: rtl/umi_gpio_initiator.sv
// Purpose : far-end UMI initiator that mirrors gpio_in into a remote umi_gpio write register
//           (posted writes) and polls the remote read register so its value lands on gpio_out.
// Latency : request valid one cycle after the IDLE decision; gpio_out updates on the response edge.
// Backpr. : requests hold valid and packet stable until umi_out_ready; responses are never stalled.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   gpio_in         local value mirrored to the remote write register
//   gpio_out        last value returned by a read poll
//   umi_out_*       request channel (valid/ready, UW-bit packet)
//   umi_in_*        response channel (ready is 1 whenever out of reset)
//   busy            FSM is not idle
//   error           sticky: read timeout or unexpected inbound packet
module umi_gpio_initiator #(
   parameter int          UW      = 256,
   parameter int          WWIDTH  = 32,
   parameter int          RWIDTH  = 32,
   parameter logic [63:0] DSTADDR = 64'h0,
   parameter logic [63:0] SRCADDR = 64'h0,
   parameter int          POLL    = 1024,
   parameter int          TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WWIDTH-1:0] gpio_in,
   output logic [RWIDTH-1:0] gpio_out,
   output logic              umi_out_valid,
   output logic [UW-1:0]     umi_out_packet,
   input  logic              umi_out_ready,
   input  logic              umi_in_valid,
   input  logic [UW-1:0]     umi_in_packet,
   output logic              umi_in_ready,
   output logic              busy,
   output logic              error
);

   localparam int          PW       = $clog2(POLL + 1);
   localparam int          TW       = $clog2(TIMEOUT + 1);
   localparam logic [7:0]  OP_WRPOST = 8'h01;
   localparam logic [7:0]  OP_READ   = 8'h08;
   localparam logic [3:0]  SIZE_4B   = 4'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND_WR,
      S_SEND_RD,
      S_WAIT_RESP
   } state_t;

   state_t            state_q;
   logic [PW-1:0]     poll_cnt_q;
   logic [TW-1:0]     timer_q;
   logic [WWIDTH-1:0] shadow_q;
   logic              force_wr_q;
   logic              valid_q;
   logic [UW-1:0]     pkt_q;
   logic [RWIDTH-1:0] gpio_out_q;
   logic              in_rdy_q;
   logic              error_q;

   logic dirty;
   logic poll_due;
   logic in_fire;
   logic resp_hit;
   logic in_pkt_unused;

   // Request packet: opcode, size, zero user field, addresses, LSB-aligned zero-filled data.
   function automatic logic [UW-1:0] build_pkt(input logic [7:0] op, input logic [WWIDTH-1:0] dat);
      logic [UW-1:0] p;
      p              = '0;
      p[7:0]         = op;
      p[11:8]        = SIZE_4B;
      p[95:32]       = DSTADDR;
      p[159:96]      = SRCADDR;
      p[160+:WWIDTH] = dat;
      return p;
   endfunction

   assign dirty    = force_wr_q | (gpio_in != shadow_q);
   assign poll_due = (poll_cnt_q == '0);
   assign in_fire  = umi_in_valid & in_rdy_q;
   // Only a posted write addressed to us, arriving while a read is outstanding, is a response.
   assign resp_hit = in_fire && (state_q == S_WAIT_RESP) &&
                     (umi_in_packet[7:0] == OP_WRPOST) && (umi_in_packet[95:32] == SRCADDR);
   // Size/user/srcaddr and upper data bits of responses are intentionally ignored.
   assign in_pkt_unused = ^umi_in_packet;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         poll_cnt_q <= PW'(POLL);
         timer_q    <= '0;
         shadow_q   <= '0;
         force_wr_q <= 1'b1;
         valid_q    <= 1'b0;
         pkt_q      <= '0;
         gpio_out_q <= '0;
         in_rdy_q   <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         in_rdy_q <= 1'b1;
         if (in_fire && !resp_hit) begin
            error_q <= 1'b1;
         end
         // Saturating countdown; a read accept below overrides it with a reload.
         if (!poll_due) begin
            poll_cnt_q <= poll_cnt_q - PW'(1);
         end
         case (state_q)
            S_IDLE: begin
               // Write wins; a due poll stays pending because the counter saturates at zero.
               if (dirty) begin
                  pkt_q   <= build_pkt(OP_WRPOST, gpio_in);
                  valid_q <= 1'b1;
                  state_q <= S_SEND_WR;
               end else if (poll_due) begin
                  pkt_q   <= build_pkt(OP_READ, '0);
                  valid_q <= 1'b1;
                  state_q <= S_SEND_RD;
               end
            end
            S_SEND_WR: begin
               if (umi_out_ready) begin
                  // The captured value, not the live gpio_in, is what the remote now holds.
                  shadow_q   <= pkt_q[160+:WWIDTH];
                  force_wr_q <= 1'b0;
                  valid_q    <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            S_SEND_RD: begin
               if (umi_out_ready) begin
                  poll_cnt_q <= PW'(POLL);
                  timer_q    <= TW'(TIMEOUT);
                  valid_q    <= 1'b0;
                  state_q    <= S_WAIT_RESP;
               end
            end
            S_WAIT_RESP: begin
               if (resp_hit) begin
                  gpio_out_q <= umi_in_packet[160+:RWIDTH];
                  state_q    <= S_IDLE;
               end else if (timer_q <= TW'(1)) begin
                  timer_q <= '0;
                  error_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gpio_out       = gpio_out_q;
   assign umi_out_valid  = valid_q;
   assign umi_out_packet = pkt_q;
   assign umi_in_ready   = in_rdy_q;
   assign busy           = (state_q != S_IDLE);
   assign error          = error_q;

endmodule
